// File: rtl/mem_req_ctrl.sv
// Request/response memory controller with a one-deep response register,
// DEPTH-word storage, address range checking and saturating access counters.
module mem_req_ctrl #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [WIDTH-1:0]      write_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      read_data,
  output logic                  rsp_err,
  output logic [15:0]           wr_count,
  output logic [15:0]           rd_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t               state_q;
  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [WIDTH-1:0]     rdata_q;
  logic                 err_q;
  logic [15:0]          wr_cnt_q;
  logic [15:0]          rd_cnt_q;

  logic                 accept;
  logic                 consume;
  logic                 addr_ok;
  logic [IDX_W-1:0]     idx;

  assign rsp_valid = (state_q == FULL);
  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready;
  assign consume   = rsp_valid && rsp_ready;
  // Compare one bit wider than the port so DEPTH == 2**ADDR_WIDTH is representable.
  assign addr_ok   = ({1'b0, address} < DEPTH_EXT);
  assign idx       = address[IDX_W-1:0];

  assign read_data = rdata_q;
  assign rsp_err   = err_q;
  assign wr_count  = wr_cnt_q;
  assign rd_count  = rd_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (accept && write_enable && addr_ok) begin
      mem_q[idx] <= write_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      case (state_q)
        EMPTY: if (accept) state_q <= FULL;
        FULL:  if (consume && !accept) state_q <= EMPTY;
        default: state_q <= EMPTY;
      endcase
      if (accept) begin
        err_q   <= !addr_ok;
        rdata_q <= (addr_ok && !write_enable) ? mem_q[idx] : '0;
        if (addr_ok && write_enable && (wr_cnt_q != 16'hFFFF)) begin
          wr_cnt_q <= wr_cnt_q + 16'd1;
        end
        if (addr_ok && !write_enable && (rd_cnt_q != 16'hFFFF)) begin
          rd_cnt_q <= rd_cnt_q + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed self-checking bench for mem_req_ctrl (DEPTH = 16, WIDTH = 32).
module tb_mem_req_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        write_enable;
  logic [7:0]  address;
  logic [31:0] write_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] read_data;
  logic        rsp_err;
  logic [15:0] wr_count;
  logic [15:0] rd_count;

  int n_checks = 0;
  int n_fail   = 0;

  mem_req_ctrl #(.WIDTH(32), .DEPTH(16), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .write_enable(write_enable), .address(address), .write_data(write_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .read_data(read_data), .rsp_err(rsp_err),
    .wr_count(wr_count), .rd_count(rd_count)
  );

  always #5 clk = ~clk;

  task automatic set_req(input logic v, input logic we, input logic [7:0] a, input logic [31:0] d);
    req_valid = v; write_enable = we; address = a; write_data = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_req(1'b0, 1'b0, 8'd0, 32'd0);
    rsp_ready = 1'b1;
    #2;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got %b exp 0", rsp_err); end
    n_checks++; if (read_data !== 32'd0) begin n_fail++; $display("FAIL reset_read_data got %h exp 0", read_data); end
    n_checks++; if (wr_count !== 16'd0 || rd_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_counts got wr %0d rd %0d exp 0 0", wr_count, rd_count); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    set_req(1'b1, 1'b1, 8'd3, 32'hDEAD_BEEF);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b1 || read_data !== 32'd0 || rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL wr_rsp got v%b d%h e%b exp v1 d0 e0", rsp_valid, read_data, rsp_err); end
    n_checks++; if (wr_count !== 16'd1) begin n_fail++; $display("FAIL wr_count1 got %0d exp 1", wr_count); end
    set_req(1'b1, 1'b0, 8'd3, 32'h0);
    @(posedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b1 || read_data !== 32'hDEAD_BEEF || rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL rd_after_wr got v%b d%h e%b exp v1 dDEADBEEF e0", rsp_valid, read_data, rsp_err); end
    n_checks++; if (rd_count !== 16'd1 || wr_count !== 16'd1) begin
      n_fail++; $display("FAIL counts_032 got wr %0d rd %0d exp 1 1", wr_count, rd_count); end
    set_req(1'b0, 1'b0, 8'd0, 32'h0);
    @(posedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL consume_empty got %b exp 0", rsp_valid); end
  endtask

  task automatic test_unwritten();
    set_req(1'b1, 1'b0, 8'd5, 32'h0);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 8'd0, 32'h0);
    n_checks++; if (read_data !== 32'd0 || rsp_err !== 1'b0 || rd_count !== 16'd2) begin
      n_fail++; $display("FAIL unwritten got d%h e%b rd%0d exp d0 e0 rd2", read_data, rsp_err, rd_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_addr_err();
    set_req(1'b1, 1'b0, 8'd16, 32'h0);
    @(posedge clk); #1;
    n_checks++; if (rsp_err !== 1'b1 || read_data !== 32'd0 || rd_count !== 16'd2) begin
      n_fail++; $display("FAIL rd_err16 got e%b d%h rd%0d exp e1 d0 rd2", rsp_err, read_data, rd_count); end
    set_req(1'b1, 1'b0, 8'd0, 32'h0);
    @(posedge clk); #1;
    n_checks++; if (rsp_err !== 1'b0 || read_data !== 32'd0 || rd_count !== 16'd3) begin
      n_fail++; $display("FAIL rd0_after_err got e%b d%h rd%0d exp e0 d0 rd3", rsp_err, read_data, rd_count); end
    set_req(1'b1, 1'b1, 8'd200, 32'h1111_2222);
    @(posedge clk); #1;
    n_checks++; if (rsp_err !== 1'b1 || read_data !== 32'd0 || wr_count !== 16'd1) begin
      n_fail++; $display("FAIL wr_err200 got e%b d%h wr%0d exp e1 d0 wr1", rsp_err, read_data, wr_count); end
    set_req(1'b1, 1'b0, 8'd8, 32'h0);
    @(posedge clk); #1;
    n_checks++; if (read_data !== 32'd0 || rsp_err !== 1'b0 || rd_count !== 16'd4) begin
      n_fail++; $display("FAIL alias8 got d%h e%b rd%0d exp d0 e0 rd4", read_data, rsp_err, rd_count); end
    set_req(1'b0, 1'b0, 8'd0, 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic test_stall_back_to_back();
    set_req(1'b1, 1'b1, 8'd7, 32'hA5A5_0001);
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    set_req(1'b1, 1'b0, 8'd7, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || read_data !== 32'd0 || rsp_err !== 1'b0 || wr_count !== 16'd2) begin
        n_fail++; $display("FAIL stall%0d got rr%b v%b d%h e%b wr%0d exp rr0 v1 d0 e0 wr2",
                           i, req_ready, rsp_valid, read_data, rsp_err, wr_count); end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL ready_release got %b exp 1", req_ready); end
    @(posedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b1 || read_data !== 32'hA5A5_0001 || rd_count !== 16'd5) begin
      n_fail++; $display("FAIL b2b_rd7 got v%b d%h rd%0d exp v1 dA5A50001 rd5", rsp_valid, read_data, rd_count); end
    set_req(1'b1, 1'b0, 8'd3, 32'h0);
    @(posedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b1 || read_data !== 32'hDEAD_BEEF || rd_count !== 16'd6) begin
      n_fail++; $display("FAIL b2b_rd3 got v%b d%h rd%0d exp v1 dDEADBEEF rd6", rsp_valid, read_data, rd_count); end
    set_req(1'b0, 1'b0, 8'd0, 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    set_req(1'b1, 1'b1, 8'd9, 32'h0000_1234);
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 8'd0, 32'h0);
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid got %b exp 1", rsp_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || wr_count !== 16'd0 || rd_count !== 16'd0) begin
      n_fail++; $display("FAIL async_reset got v%b rr%b wr%0d rd%0d exp v0 rr1 wr0 rd0",
                         rsp_valid, req_ready, wr_count, rd_count); end
    rsp_ready = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    set_req(1'b1, 1'b0, 8'd9, 32'h0);
    #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL stale_rsp got %b exp 0", rsp_valid); end
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 8'd0, 32'h0);
    n_checks++; if (rsp_valid !== 1'b1 || read_data !== 32'd0 || rd_count !== 16'd1) begin
      n_fail++; $display("FAIL rd_after_reset got v%b d%h rd%0d exp v1 d0 rd1", rsp_valid, read_data, rd_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_saturate();
    rst_n = 1'b0;
    #2;
    @(negedge clk) rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 1; i <= 65540; i++) begin
      set_req(1'b1, 1'b1, 8'(i % 16), 32'(i));
      @(posedge clk); #1;
      if (i == 65534) begin
        n_checks++; if (wr_count !== 16'hFFFE) begin n_fail++; $display("FAIL sat_65534 got %h exp FFFE", wr_count); end
      end
      if (i == 65535) begin
        n_checks++; if (wr_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_65535 got %h exp FFFF", wr_count); end
      end
    end
    set_req(1'b0, 1'b0, 8'd0, 32'h0);
    n_checks++; if (wr_count !== 16'hFFFF || rd_count !== 16'd0) begin
      n_fail++; $display("FAIL sat_final got wr %h rd %0d exp FFFF 0", wr_count, rd_count); end
    set_req(1'b1, 1'b0, 8'd4, 32'h0);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 8'd0, 32'h0);
    n_checks++; if (read_data !== 32'd65540) begin
      n_fail++; $display("FAIL sat_last_data got %0d exp 65540", read_data); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_unwritten();
    test_addr_err();
    test_stall_back_to_back();
    test_reset_mid();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_req_ctrl.md
MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, number of storage words, range 2..256.
REQ-003 SHALL have parameter ADDR_WIDTH, default 8, address port width, at least clog2(DEPTH).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-008 SHALL have port write_enable  input  1  request type: 1 = write, 0 = read.
REQ-009 SHALL have port address  input  ADDR_WIDTH  word address.
REQ-010 SHALL have port write_data  input  WIDTH  write payload.
REQ-011 SHALL have port rsp_valid  output  1  response present.
REQ-012 SHALL have port rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-013 SHALL have port read_data  output  WIDTH  read result; 0 for writes and errors.
REQ-014 SHALL have port rsp_err  output  1  request address >= DEPTH.
REQ-015 SHALL have port wr_count  output  16  accepted good writes, saturating.
REQ-016 SHALL have port rd_count  output  16  accepted good reads, saturating.

Function
REQ-017 SHALL accept a request on a rising edge where req_valid && req_ready.
REQ-018 SHALL drive req_ready = !rsp_valid || rsp_ready. This gives a one-deep response register, full throughput, and no combinational path from req_valid.
REQ-019 SHALL produce exactly one response per accepted request, in order. rsp_valid rises on the edge that accepts the request, giving 1-cycle latency.
REQ-020 SHALL hold rsp_valid, read_data and rsp_err stable while rsp_valid && !rsp_ready.
REQ-021 SHALL clear rsp_valid on a consuming edge (rsp_valid && rsp_ready) unless a new request is accepted on the same edge. In that case rsp_valid SHALL stay 1 and the response fields SHALL carry the new request's result.
REQ-022 SHALL, on an accepted write with address < DEPTH, store write_data at that address on the accepting edge and respond with read_data = 0, rsp_err = 0.
REQ-023 SHALL, on an accepted read with address < DEPTH, respond with the word stored at that address, including a write accepted on the immediately preceding edge.
REQ-024 SHALL, on any accepted request with address >= DEPTH, leave storage unchanged, respond with rsp_err = 1 and read_data = 0, and leave both counters unchanged.
REQ-025 SHALL increment wr_count or rd_count by 1 per good accepted write or read, saturating at 16'hFFFF with no wrap.
REQ-026 SHALL implement the control state as a 2-state FSM:
  - EMPTY: rsp_valid = 0. Goes to FULL on accept.
  - FULL: rsp_valid = 1. Goes to EMPTY on consume without accept; stays FULL on consume with accept or on stall.
REQ-027 SHALL ignore write_enable, address and write_data in any cycle without an accept.

Reset
REQ-028 SHALL, while rst_n = 0, immediately force:
  - FSM to EMPTY;
  - rsp_valid = 0, rsp_err = 0, read_data = 0;
  - wr_count = 0, rd_count = 0;
  - all DEPTH storage words = 0.
REQ-029 SHALL drive req_ready = 1 during and after reset.
REQ-030 SHALL discard any response pending at reset assertion mid-operation; no response is ever issued for it.
REQ-031 SHALL accept a request on the first rising edge after rst_n deasserts.

Verification
REQ-032 Write addr 3 data 32'hDEAD_BEEF, then read addr 3 on the next cycle with rsp_ready = 1 -> responses (0, err 0) then (32'hDEAD_BEEF, err 0); wr_count = 1, rd_count = 1.
REQ-033 Read addr 5 after reset, no prior write -> read_data = 0, rsp_err = 0.
REQ-034 Read addr 16 with DEPTH = 16 -> rsp_err = 1, read_data = 0, counters unchanged; a subsequent read of addr 0 is unaffected.
REQ-035 Hold rsp_ready = 0 for 3 cycles with a response pending -> req_ready = 0 and response fields stable for those cycles. Raising rsp_ready with req_valid held high gives back-to-back accept and consume, with rsp_valid continuously 1.
REQ-036 Issue 65 540 good writes -> wr_count stays at 16'hFFFF after the 65 535th write.
REQ-037 Assert rst_n = 0 mid-cycle while rsp_valid = 1 -> rsp_valid drops asynchronously. After release, reading a previously written address returns 0.
